// File: rtl/parity_frame_ctrl_pkg.sv
// Shared definitions for the serial parity frame receiver: state encoding,
// default word width and the idle level of the serial line.
package parity_frame_ctrl_pkg;

    localparam int unsigned DEFAULT_N   = 8;
    localparam int unsigned STATE_W     = 3;
    localparam logic        IDLE_LEVEL  = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PAR     = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

endpackage : parity_frame_ctrl_pkg

// File: rtl/parity_frame_ctrl_sync_bit.sv
// Single-bit input register with asynchronous active-high reset to a
// parameterised value.
module parity_frame_ctrl_sync_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : parity_frame_ctrl_sync_bit

// File: rtl/parity_frame_ctrl.sv
// Bit-serial frame receiver: start(0), N data bits LSB first, parity, stop(1).
// Deserialises the word, accumulates parity by toggling, and reports status.
module parity_frame_ctrl
    import parity_frame_ctrl_pkg::*;
#(
    parameter int unsigned N   = DEFAULT_N,
    parameter logic        ODD = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx_in,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         parity_err,
    output logic         frame_err,
    output logic         busy
);

    localparam int unsigned CW = $clog2(N + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           par_acc;
    logic [N-1:0]   shreg;
    logic           rx_s;

    // Line register; resets to the idle level so reset never looks like a start bit.
    parity_frame_ctrl_sync_bit #(
        .RST_VAL (IDLE_LEVEL)
    ) u_sync_rx (
        .clock (clock),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            par_acc    <= 1'b0;
            shreg      <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_DATA;
                        cnt     <= '0;
                        par_acc <= 1'b0;
                    end
                end
                ST_DATA: begin
                    // Right shift: the first (LSB) bit ends up in bit 0 after N shifts.
                    shreg   <= {rx_s, shreg[N-1:1]};
                    par_acc <= par_acc ^ rx_s;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state <= ST_PAR;
                    end
                end
                ST_PAR: begin
                    par_acc <= par_acc ^ rx_s;
                    state   <= ST_STOP;
                end
                ST_STOP: begin
                    data_out   <= shreg;
                    valid      <= 1'b1;
                    parity_err <= par_acc ^ ODD;
                    frame_err  <= ~rx_s;
                    state      <= rx_s ? ST_IDLE : ST_RECOVER;
                end
                ST_RECOVER: begin
                    // A low line here is a broken stop, never a new start.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule : parity_frame_ctrl
